// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx -- UART-style serial transmitter
//
// Sends one frame per accepted load: a start bit (0), DATA_BITS data bits LSB
// first, an optional even-parity bit, then a stop bit (1). Each bit is held
// on the line for BIT_PERIOD clock cycles. Every output comes straight from a
// register.
//
// Parameters:
//   BIT_PERIOD  clock cycles per serial bit (2..255)
//   DATA_BITS   data bits per frame (1..8)
//   PARITY_EN   1 inserts an even-parity bit after the data bits
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   tx_data     byte to send; only bits [DATA_BITS-1:0] are transmitted
//   load        start a frame; taken only while tx_ready is high
//   tx_ready    high when a load will be accepted
//   serial_out  serial line; idle/stop level 1, start level 0
//   tx_done     one-cycle pulse as the frame completes
// -----------------------------------------------------------------------------
module serial_tx #(
  parameter int BIT_PERIOD = 10,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       load,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_done
);

  localparam logic [7:0] CNT_LAST = 8'(BIT_PERIOD - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [2:0] r_idx, w_idx_next;
  logic [7:0] r_shift, w_shift_next;
  logic       r_parity, w_parity_next;
  logic       r_serial, w_serial_next;
  logic       r_ready, w_ready_next;
  logic       r_done, w_done_next;

  logic [7:0] w_data_masked;
  logic       w_wrap;
  logic       w_unused_data;

  // Zero the bits above DATA_BITS so they can neither reach the line nor
  // disturb the parity.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      if (gi < DATA_BITS) begin : g_used
        assign w_data_masked[gi] = tx_data[gi];
      end else begin : g_zero
        assign w_data_masked[gi] = 1'b0;
      end
    end
  endgenerate

  // High tx_data bits are legitimately ignored for narrow frames.
  assign w_unused_data = ^tx_data;

  assign w_wrap = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_serial_next = r_serial;
    w_done_next   = 1'b0;

    // The bit-period counter runs in every non-idle state and wraps at the
    // end of each bit; the state decode below only reacts to the wrap.
    if (r_state != ST_IDLE) begin
      w_cnt_next = w_wrap ? 8'd0 : r_cnt + 8'd1;
    end

    case (r_state)
      ST_IDLE: begin
        w_serial_next = 1'b1;
        if (load && r_ready) begin
          w_state_next  = ST_START;
          w_cnt_next    = 8'd0;
          w_idx_next    = 3'd0;
          w_shift_next  = w_data_masked;
          w_parity_next = ^w_data_masked;
          w_serial_next = 1'b0;
        end
      end

      ST_START: begin
        if (w_wrap) begin
          w_state_next  = ST_DATA;
          w_idx_next    = 3'd0;
          w_serial_next = r_shift[0];
        end
      end

      ST_DATA: begin
        if (w_wrap) begin
          if (r_idx == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              w_state_next  = ST_PARITY;
              w_serial_next = r_parity;
            end else begin
              w_state_next  = ST_STOP;
              w_serial_next = 1'b1;
            end
          end else begin
            // Next data bit is the one just above the current LSB.
            w_idx_next    = r_idx + 3'd1;
            w_shift_next  = r_shift >> 1;
            w_serial_next = r_shift[1];
          end
        end
      end

      ST_PARITY: begin
        if (w_wrap) begin
          w_state_next  = ST_STOP;
          w_serial_next = 1'b1;
        end
      end

      ST_STOP: begin
        if (w_wrap) begin
          w_state_next  = ST_IDLE;
          w_serial_next = 1'b1;
          w_done_next   = 1'b1;
        end
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_cnt_next    = 8'd0;
        w_serial_next = 1'b1;
      end
    endcase

    // Ready is registered from the next state so a load can be taken in the
    // same cycle that tx_done is high.
    w_ready_next = (w_state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_idx    <= 3'd0;
      r_shift  <= 8'd0;
      r_parity <= 1'b0;
      r_serial <= 1'b1;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_serial <= w_serial_next;
      r_ready  <= w_ready_next;
      r_done   <= w_done_next;
    end
  end

  assign serial_out = r_serial;
  assign tx_ready   = r_ready;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx -- bench for serial_tx
//
// Three instances cover the default frame (10/8/no parity), a parity frame
// (4/8/parity) and a narrow frame (2/5/no parity). The stimulus process pushes
// the hand-computed line pattern of each frame into a queue when it issues the
// load; the monitor process pops an entry when it sees tx_ready fall and then
// checks every cycle of the frame, the tx_done timing and reset behaviour.
// -----------------------------------------------------------------------------
module tb_serial_tx;

  typedef struct {
    int          cfg;
    logic [15:0] bits;   // line bits, first transmitted bit at index nbits-1
    int          nbits;
    int          gap;    // required cycles since previous tx_done, 0 = don't care
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic [2:0] load;
  logic [2:0] tx_ready;
  logic [2:0] serial_out;
  logic [2:0] tx_done;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  bit   end_req;
  bit   end_ack;

  serial_tx u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .load(load[0]),
    .tx_ready(tx_ready[0]), .serial_out(serial_out[0]), .tx_done(tx_done[0])
  );

  serial_tx #(.BIT_PERIOD(4), .DATA_BITS(8), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .load(load[1]),
    .tx_ready(tx_ready[1]), .serial_out(serial_out[1]), .tx_done(tx_done[1])
  );

  serial_tx #(.BIT_PERIOD(2), .DATA_BITS(5), .PARITY_EN(0)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .load(load[2]),
    .tx_ready(tx_ready[2]), .serial_out(serial_out[2]), .tx_done(tx_done[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bp_of(input int c);
    case (c)
      0:       return 10;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic void chk(input string name, input logic [15:0] act,
                              input logic [15:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else n_pass++;
  endfunction

  // ---------------------------------------------------------------- monitor
  int   cycle_no;
  bit   prev_rst;
  bit   busy       [3];
  bit   after_done [3];
  bit   prev_ready [3];
  bit   bit_ok     [3];
  bit   flags_ok   [3];
  logic bad_val    [3];
  int   cyc        [3];
  int   last_done  [3];
  exp_t cur        [3];

  initial begin
    cycle_no = 0;
    prev_rst = 1'b0;
    n_pass   = 0;
    n_total  = 0;
    end_ack  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      busy[c]       = 1'b0;
      after_done[c] = 1'b0;
      prev_ready[c] = 1'b1;
      last_done[c]  = 0;
    end
  end

  always @(negedge clk) begin
    int   f;
    int   k;
    int   bp;
    logic eb;
    cycle_no = cycle_no + 1;
    for (int c = 0; c < 3; c++) begin
      bp = bp_of(c);
      if (prev_rst) begin
        // The last rising edge saw rst=1: idle outputs, frame dropped.
        chk($sformatf("cfg%0d_reset_state", c),
            {13'd0, serial_out[c], tx_ready[c], tx_done[c]}, 16'b110);
        busy[c]       = 1'b0;
        after_done[c] = 1'b0;
      end else begin
        if (!busy[c]) begin
          if (after_done[c]) begin
            chk($sformatf("cfg%0d_done_width", c), {15'd0, tx_done[c]}, 16'd0);
            after_done[c] = 1'b0;
          end else if (tx_done[c] !== 1'b0) begin
            chk($sformatf("cfg%0d_spurious_done", c), {15'd0, tx_done[c]}, 16'd0);
          end
          if (tx_ready[c] === 1'b0 && prev_ready[c]) begin
            if (exp_q.size() > 0 && exp_q[0].cfg == c) begin
              cur[c]      = exp_q.pop_front();
              busy[c]     = 1'b1;
              cyc[c]      = 0;
              bit_ok[c]   = 1'b1;
              flags_ok[c] = 1'b1;
            end else begin
              chk($sformatf("cfg%0d_unexpected_frame", c), {15'd0, tx_ready[c]}, 16'd1);
            end
          end
        end
        if (busy[c]) begin
          f = cur[c].nbits * bp;
          if (cyc[c] < f) begin
            k  = cyc[c] / bp;
            eb = cur[c].bits[cur[c].nbits - 1 - k];
            if (serial_out[c] !== eb) begin
              bit_ok[c]  = 1'b0;
              bad_val[c] = serial_out[c];
            end
            if (tx_ready[c] !== 1'b0 || tx_done[c] !== 1'b0) flags_ok[c] = 1'b0;
            if (cyc[c] % bp == bp - 1) begin
              chk($sformatf("cfg%0d_bit%0d", c, k),
                  {15'd0, (bit_ok[c] ? eb : bad_val[c])}, {15'd0, eb});
              bit_ok[c] = 1'b1;
            end
          end else begin
            chk($sformatf("cfg%0d_frame_end_done_ready", c),
                {14'd0, tx_done[c], tx_ready[c]}, 16'b11);
            chk($sformatf("cfg%0d_busy_ready_done_low", c), {15'd0, flags_ok[c]}, 16'd1);
            if (cur[c].gap > 0) begin
              chk($sformatf("cfg%0d_done_spacing", c),
                  16'(cycle_no - last_done[c]), 16'(cur[c].gap));
            end
            $display("cfg%0d frame of %0d bits ended at cycle %0d", c, cur[c].nbits, cycle_no);
            last_done[c]  = cycle_no;
            busy[c]       = 1'b0;
            after_done[c] = 1'b1;
          end
          cyc[c] = cyc[c] + 1;
          if (rst && busy[c]) begin
            $display("cfg%0d frame aborted by reset at frame cycle %0d", c, cyc[c] - 1);
            busy[c] = 1'b0;
          end
        end
      end
      prev_ready[c] = (tx_ready[c] === 1'b1);
    end
    prev_rst = (rst === 1'b1);
    if (end_req && !end_ack) begin
      chk("queue_drained", 16'(exp_q.size()), 16'd0);
      chk("all_idle", {13'd0, busy[2], busy[1], busy[0]}, 16'd0);
      end_ack = 1'b1;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int c, input logic [7:0] d, input logic [15:0] bits,
                       input int nbits, input int gap);
    exp_t e;
    e.cfg   = c;
    e.bits  = bits;
    e.nbits = nbits;
    e.gap   = gap;
    exp_q.push_back(e);
    load[c] = 1'b1;
    tx_data = d;
    tick();
    load[c] = 1'b0;
  endtask

  task automatic wait_ready(input int c);
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready[c] === 1'b1) return;
      tick();
    end
    $display("FAIL cfg%0d_ready_timeout: tx_ready stayed low, expected high within 2000 cycles", c);
    $fatal(1, "timeout");
  endtask

  task automatic wait_done(input int c);
    for (int i = 0; i < 2000; i++) begin
      if (tx_done[c] === 1'b1) return;
      tick();
    end
    $display("FAIL cfg%0d_done_timeout: tx_done stayed low, expected a pulse within 2000 cycles", c);
    $fatal(1, "timeout");
  endtask

  initial begin
    rst     = 1'b1;
    load    = 3'b000;
    tx_data = 8'h00;
    end_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Default frame: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    wait_ready(0);
    issue(0, 8'hA5, 16'(10'b0101001011), 10, 0);

    // 0x00 then 0xFF loaded in the tx_done cycle: done pulses 101 apart
    wait_ready(0);
    repeat (3) tick();
    issue(0, 8'h00, 16'(10'b0000000001), 10, 0);
    wait_done(0);
    issue(0, 8'hFF, 16'(10'b0111111111), 10, 101);

    // 0x96 in flight, load of 0x3C at E0+35 must be ignored
    wait_ready(0);
    repeat (2) tick();
    issue(0, 8'h96, 16'(10'b0011010011), 10, 0);
    repeat (34) @(posedge clk);
    #1;
    load[0] = 1'b1;
    tx_data = 8'h3C;
    tick();
    load[0] = 1'b0;

    // 0x5A aborted by a one-cycle reset at E0+47, load held during reset
    wait_ready(0);
    repeat (2) tick();
    issue(0, 8'h5A, 16'(10'b0010110101), 10, 0);
    repeat (46) @(posedge clk);
    #1;
    rst     = 1'b1;
    load[0] = 1'b1;
    tx_data = 8'h81;
    tick();
    rst     = 1'b0;
    load[0] = 1'b0;
    repeat (5) tick();
    issue(0, 8'h81, 16'(10'b0100000011), 10, 0);

    // Parity frames, 44 cycles each: 0x07 -> parity 1, 0x03 -> parity 0
    wait_ready(1);
    issue(1, 8'h07, 16'(11'b01110000011), 11, 0);
    wait_ready(1);
    repeat (2) tick();
    issue(1, 8'h03, 16'(11'b01100000001), 11, 0);

    // Five-bit frames: upper tx_data bits never reach the line
    wait_ready(2);
    issue(2, 8'h1F, 16'(7'b0111111), 7, 0);
    wait_done(2);
    issue(2, 8'hE0, 16'(7'b0000001), 7, 15);
    wait_ready(2);
    repeat (2) tick();
    issue(2, 8'hB5, 16'(7'b0101011), 7, 0);

    wait_ready(0);
    wait_ready(1);
    wait_ready(2);
    repeat (5) tick();
    end_req = 1'b1;
    for (int i = 0; i < 20 && !end_ack; i++) tick();
    if (!end_ack) begin
      $display("FAIL end_handshake: monitor did not respond, expected acknowledge");
      $fatal(1, "timeout");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
